seq_restoring_divider: RTL and testbench

Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the approximate multiplier datapath: it recovers quotient and remainder using a ripple chain of full subtractors. The chain has the same maskable-carry idea as the adder, applied here to borrows, so approximate division can be characterised against the exact mode. It sits beside the multiplier as a standalone start/done coprocessor block.

---
 rtl/div_pkg.sv | 20 ++
 rtl/fullsubtractor.sv | 13 +
 rtl/seq_restoring_divider.sv | 118 +++++++++++
 tb/tb_seq_restoring_divider.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and counter sizing.
package div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

  // Width of the iteration counter; it must hold WIDTH-1.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow-out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, with an
// optionally borrow-masked subtractor chain for approximate division studies.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MASK_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] r_d, q_d;
  logic [CW-1:0]    count_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH:0]   s, dvs, t, bout_raw;
  logic [WIDTH+1:0] borrow;
  logic             unused_t_msb;

  assign s         = {r_q, q_q[WIDTH-1]};
  assign dvs       = {1'b0, d_q};
  assign borrow[0] = 1'b0;

  // Masking is applied outside the cell so the cell stays a plain subtractor.
  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
      fullsubtractor u_fs (
        .a    (s[gi]),
        .b    (dvs[gi]),
        .bin  (borrow[gi]),
        .diff (t[gi]),
        .bout (bout_raw[gi])
      );
      assign borrow[gi+1] = (gi < MASK_BITS) ? 1'b0 : bout_raw[gi];
    end
  endgenerate

  assign unused_t_msb = t[WIDTH];

  always_comb begin
    r_d = borrow[WIDTH+1] ? s[WIDTH-1:0] : t[WIDTH-1:0];
    q_d = {q_q[WIDTH-2:0], ~borrow[WIDTH+1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              d_q     <= divisor;
              q_q     <= dividend;
              r_q     <= '0;
              count_q <= CW'(WIDTH - 1);
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_q     <= r_d;
          q_q     <= q_d;
          count_q <= count_q - CW'(1);
          if (count_q == '0) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of the restoring divider in exact (MASK_BITS=0)
// and approximate (MASK_BITS=2) configurations.
module tb_seq_restoring_divider;

  logic       clk, rst;
  logic       start, busy, done, dbz;
  logic [7:0] dividend, divisor, quotient, remainder;
  logic       start_m, busy_m, done_m, dbz_m;
  logic [7:0] dividend_m, divisor_m, quotient_m, remainder_m;

  int n_cmp, n_err;

  seq_restoring_divider #(.WIDTH(8), .MASK_BITS(0)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(dbz)
  );

  seq_restoring_divider #(.WIDTH(8), .MASK_BITS(2)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .dividend(dividend_m), .divisor(divisor_m),
    .busy(busy_m), .done(done_m), .quotient(quotient_m), .remainder(remainder_m),
    .div_by_zero(dbz_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         dk;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bit-level model of the borrow-masked restoring divider.
  function automatic logic [15:0] masked_div(input logic [7:0] a, input logic [7:0] b,
                                             input int mb);
    logic [7:0] rr, qq;
    logic [8:0] s, t;
    logic       bw, ai, bi, raw;
    if (b == 8'd0) return {8'hff, a};
    rr = 8'd0;
    qq = a;
    for (int it = 0; it < 8; it++) begin
      s  = {rr, qq[7]};
      t  = 9'd0;
      bw = 1'b0;
      for (int i = 0; i < 9; i++) begin
        ai   = s[i];
        bi   = (i < 8) ? b[i] : 1'b0;
        t[i] = ai ^ bi ^ bw;
        raw  = (~ai & bi) | (~(ai ^ bi) & bw);
        bw   = (i < mb) ? 1'b0 : raw;
      end
      if (bw) begin
        rr = s[7:0];
        qq = {qq[6:0], 1'b0};
      end else begin
        rr = t[7:0];
        qq = {qq[6:0], 1'b1};
      end
    end
    return {qq, rr};
  endfunction

  // k counts negedges after the accepting edge (k=0 is the cycle right after it).
  task automatic wait_done(output int dk, output int bn);
    dk = -1;
    bn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) bn++;
      if (done) begin
        dk = k;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int dk, output int bn);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(dk, bn);
  endtask

  initial begin
    int dk, bn, dcount;
    logic [7:0] a, b, eq, er;
    logic [15:0] mres;
    logic seen_e, seen_m;

    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    start_m = 1'b0; dividend_m = '0; divisor_m = '0;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   dbz: 1'b0, dk: 8};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dbz: 1'b0, dk: 8};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dbz: 1'b0, dk: 8};
    vecs[3] = '{a: 8'd200, b: 8'd200, q: 8'd1,   r: 8'd0,   dbz: 1'b0, dk: 8};
    vecs[4] = '{a: 8'd128, b: 8'd255, q: 8'd0,   r: 8'd128, dbz: 1'b0, dk: 8};
    vecs[5] = '{a: 8'd37,  b: 8'd0,   q: 8'd255, r: 8'd37,  dbz: 1'b1, dk: 0};
    vecs[6] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   dbz: 1'b0, dk: 8};

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    check("rst_busy_m", 32'(busy_m), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, dk, bn);
      $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d done_at=%0d busy_cycles=%0d",
               vecs[i].a, vecs[i].b, quotient, remainder, dbz, dk, bn);
      check("vec_quot", 32'(quotient), 32'(vecs[i].q));
      check("vec_rem", 32'(remainder), 32'(vecs[i].r));
      check("vec_dbz", 32'(dbz), 32'(vecs[i].dbz));
      check("vec_done_at", 32'(dk), 32'(vecs[i].dk));
      check("vec_busy_cycles", 32'(bn), 32'(vecs[i].dk));
      @(negedge clk);
      check("vec_done_pulse", 32'(done), 32'd0);
    end

    // start pulsed while RUN must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    dk = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        dk = k;
        break;
      end
      if (k == 2) begin start = 1'b1; dividend = 8'd50; divisor = 8'd6; end
      if (k == 3) start = 1'b0;
    end
    $display("op 100/7 with mid-run start -> q=%0d r=%0d done_at=%0d", quotient, remainder, dk);
    check("midstart_done_at", 32'(dk), 32'd8);
    check("midstart_quot", 32'(quotient), 32'd14);
    check("midstart_rem", 32'(remainder), 32'd2);

    // back-to-back: start held in the DONE cycle
    run_op(8'd100, 8'd7, dk, bn);
    check("b2b_first_done_at", 32'(dk), 32'd8);
    start = 1'b1; dividend = 8'd50; divisor = 8'd6;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_first_quot", 32'(quotient), 32'd14);
    wait_done(dk, bn);
    $display("op 50/6 back-to-back -> q=%0d r=%0d done_at=%0d busy_cycles=%0d",
             quotient, remainder, dk, bn);
    check("b2b_done_at", 32'(dk), 32'd8);
    check("b2b_busy_cycles", 32'(bn), 32'd8);
    check("b2b_quot", 32'(quotient), 32'd8);
    check("b2b_rem", 32'(remainder), 32'd2);

    // asynchronous reset during RUN
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quot", 32'(quotient), 32'd0);
    check("abort_rem", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    run_op(8'd50, 8'd6, dk, bn);
    $display("op 50/6 after abort -> q=%0d r=%0d done_at=%0d", quotient, remainder, dk);
    check("post_abort_quot", 32'(quotient), 32'd8);
    check("post_abort_rem", 32'(remainder), 32'd2);
    check("post_abort_done_at", 32'(dk), 32'd8);

    // random pairs: exact instance vs true division, masked instance vs model
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      @(negedge clk);
      start = 1'b1;   dividend = a;   divisor = b;
      start_m = 1'b1; dividend_m = a; divisor_m = b;
      @(posedge clk);
      #1 start = 1'b0; start_m = 1'b0;
      seen_e = 1'b0; seen_m = 1'b0;
      for (int k = 0; k < 20 && !(seen_e && seen_m); k++) begin
        @(negedge clk);
        if (done) seen_e = 1'b1;
        if (done_m) seen_m = 1'b1;
      end
      check("rnd_done_seen", 32'({seen_e, seen_m}), 32'd3);
      if (b == 8'd0) begin
        eq = 8'hff; er = a;
      end else begin
        eq = a / b; er = a % b;
      end
      mres = masked_div(a, b, 2);
      $display("rnd %0d: %0d/%0d exact q=%0d r=%0d masked q=%0d r=%0d",
               n, a, b, quotient, remainder, quotient_m, remainder_m);
      check("rnd_exact", 32'({quotient, remainder}), 32'({eq, er}));
      check("rnd_masked", 32'({quotient_m, remainder_m}), 32'(mres));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
